// File: rtl/sid_env_pkg.sv
`timescale 1ns/1ps
// Shared types, rate/LFSR tables and reset constants for the
// three-voice SID envelope scheduler (sid_env_sched).
package sid_env_pkg;

    localparam int NUM_VOICES = 3;

    localparam int VOICE_STRIDE = 7;
    localparam int OFF_GATE     = 4;
    localparam int OFF_AD       = 5;
    localparam int OFF_SR       = 6;

    typedef struct packed {
        logic [7:0]  env;
        logic [14:0] lfsr15;
        logic [4:0]  lfsr5;
        logic [5:0]  sel;
        logic        dir;
        logic        gate_lag;
    } env_ctx_t;

    typedef struct packed {
        logic       gate;
        logic [3:0] att;
        logic [3:0] dec;
        logic [3:0] sus;
        logic [3:0] rel;
    } voice_cfg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN0,
        S_RUN1,
        S_RUN2
    } sched_state_t;

    localparam env_ctx_t CTX_RST = '{
        env:      8'h00,
        lfsr15:   15'h7FFF,
        lfsr5:    5'h1F,
        sel:      6'b000001,
        dir:      1'b0,
        gate_lag: 1'b0
    };

    localparam voice_cfg_t CFG_RST = '{
        gate: 1'b0,
        att:  4'h0,
        dec:  4'h0,
        sus:  4'hF,
        rel:  4'h0
    };

    // 15-bit LFSR value that ends one rate period
    function automatic logic [14:0] rate_tbl(input logic [3:0] r);
        logic [14:0] v;
        case (r)
            4'd0:    v = 15'h7F00;
            4'd1:    v = 15'h0006;
            4'd2:    v = 15'h003C;
            4'd3:    v = 15'h0330;
            4'd4:    v = 15'h20C0;
            4'd5:    v = 15'h6755;
            4'd6:    v = 15'h3800;
            4'd7:    v = 15'h500E;
            4'd8:    v = 15'h1212;
            4'd9:    v = 15'h0222;
            4'd10:   v = 15'h1848;
            4'd11:   v = 15'h59B8;
            4'd12:   v = 15'h3840;
            4'd13:   v = 15'h77E2;
            4'd14:   v = 15'h7625;
            default: v = 15'h0A93;
        endcase
        return v;
    endfunction

    function automatic logic [5:0] lfsr5_match(input logic [4:0] l);
        return {l == 5'h0F, l == 5'h08, l == 5'h1B,
                l == 5'h11, l == 5'h1C, l == 5'h1E};
    endfunction

    function automatic logic dec_thr(input logic [7:0] e);
        return (e == 8'h5D) || (e == 8'h36) || (e == 8'h1A) ||
               (e == 8'h0E) || (e == 8'h06) || (e == 8'h00);
    endfunction

endpackage

// File: rtl/sid_env_step.sv
`timescale 1ns/1ps
// One envelope step for a single voice: stored context plus voice
// configuration in, next context out. Purely combinational.
module sid_env_step
    import sid_env_pkg::*;
(
    input  env_ctx_t   i_ctx,
    input  logic       i_gate,
    input  logic [3:0] i_att,
    input  logic [3:0] i_dec,
    input  logic [3:0] i_sus,
    input  logic [3:0] i_rel,
    output env_ctx_t   o_ctx
);

    logic [3:0]  w_rate;
    logic [14:0] w_n15;
    logic [4:0]  w_n5;
    logic        w_r15;
    logic        w_r5;
    logic [7:0]  w_lvl;

    always_comb begin
        w_rate = !i_gate ? i_rel : (i_ctx.dir ? i_att : i_dec);
        w_n15  = {i_ctx.lfsr15[13:0], i_ctx.lfsr15[13] ^ i_ctx.lfsr15[14]};
        w_n5   = {i_ctx.lfsr5[3:0], i_ctx.lfsr5[2] ^ i_ctx.lfsr5[4]};
        w_r15  = (w_n15 == rate_tbl(w_rate));
        w_r5   = w_r15 && |(lfsr5_match(w_n5) & i_ctx.sel);
        w_lvl  = {i_sus, i_sus};
    end

    always_comb begin
        o_ctx = i_ctx;

        o_ctx.lfsr15 = w_r15 ? 15'h7FFF : w_n15;
        if (w_r15) begin
            o_ctx.lfsr5 = w_r5 ? 5'h1F : w_n5;
        end

        if (!i_gate) begin
            o_ctx.dir = 1'b0;
        end else if (!i_ctx.gate_lag) begin
            o_ctx.dir = 1'b1;
        end else if (i_ctx.env == 8'hFF) begin
            o_ctx.dir = 1'b0;
        end
        o_ctx.gate_lag = i_gate;

        if (i_ctx.dir) begin
            o_ctx.sel = 6'b000001;
        end else if (w_r5 && dec_thr(i_ctx.env)) begin
            o_ctx.sel = i_ctx.sel << 1;
        end

        // decay only moves down toward sustain; a raised level holds env
        if (!i_gate) begin
            if (i_ctx.env != 8'h00 && w_r5) begin
                o_ctx.env = i_ctx.env - 8'd1;
            end
        end else if (!i_ctx.dir) begin
            if (i_ctx.env > w_lvl && w_r5) begin
                o_ctx.env = i_ctx.env - 8'd1;
            end
        end else if (w_r15 && i_ctx.env != 8'hFF) begin
            o_ctx.env = i_ctx.env + 8'd1;
        end
    end

endmodule

// File: rtl/sid_env_sched.sv
`timescale 1ns/1ps
// Time-multiplexed envelope controller for three SID voices.
// Define SID_ENV_READBACK_EN for the ENV3 capture register (offset 1C).
module sid_env_sched
    import sid_env_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR = 5'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLKen,
    input  logic       WR,
    input  logic [4:0] ADDR,
    input  logic [7:0] DATA,
    output logic [7:0] OUT0,
    output logic [7:0] OUT1,
    output logic [7:0] OUT2,
    output logic       BUSY,
    output logic       OVERRUN,
    output logic [7:0] ENV3
);

    sched_state_t r_state;
    logic         r_pend;
    logic         r_busy;
    logic         r_overrun;

    env_ctx_t     r_ctx [NUM_VOICES];
    voice_cfg_t   r_cfg [NUM_VOICES];

    logic [4:0]   w_off;
    logic [2:0]   w_run;
    env_ctx_t     w_ctx;
    env_ctx_t     w_ctx_nxt;
    voice_cfg_t   w_cfg;

    assign w_off = ADDR - BASE_ADDR;
    assign w_run = {r_state == S_RUN2, r_state == S_RUN1, r_state == S_RUN0};

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_cfg[v] <= CFG_RST;
            end
        end else if (WR) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_off == 5'(VOICE_STRIDE * v + OFF_GATE)) begin
                    r_cfg[v].gate <= DATA[0];
                end
                if (w_off == 5'(VOICE_STRIDE * v + OFF_AD)) begin
                    r_cfg[v].att <= DATA[7:4];
                    r_cfg[v].dec <= DATA[3:0];
                end
                if (w_off == 5'(VOICE_STRIDE * v + OFF_SR)) begin
                    r_cfg[v].sus <= DATA[7:4];
                    r_cfg[v].rel <= DATA[3:0];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_pend    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (CLKen || r_pend) begin
                        r_state <= S_RUN0;
                        r_busy  <= 1'b1;
                        r_pend  <= 1'b0;
                    end
                end
                S_RUN0: r_state <= S_RUN1;
                S_RUN1: r_state <= S_RUN2;
                S_RUN2: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // one tick may queue behind a running sequence; a second is lost
            if (r_state != S_IDLE && CLKen) begin
                if (r_pend) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ctx = r_ctx[0];
        w_cfg = r_cfg[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (w_run[v]) begin
                w_ctx = r_ctx[v];
                w_cfg = r_cfg[v];
            end
        end
    end

    sid_env_step u_step (
        .i_ctx  (w_ctx),
        .i_gate (w_cfg.gate),
        .i_att  (w_cfg.att),
        .i_dec  (w_cfg.dec),
        .i_sus  (w_cfg.sus),
        .i_rel  (w_cfg.rel),
        .o_ctx  (w_ctx_nxt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_ctx[v] <= CTX_RST;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_run[v]) begin
                    r_ctx[v] <= w_ctx_nxt;
                end
            end
        end
    end

    assign OUT0    = r_ctx[0].env;
    assign OUT1    = r_ctx[1].env;
    assign OUT2    = r_ctx[2].env;
    assign BUSY    = r_busy;
    assign OVERRUN = r_overrun;

`ifdef SID_ENV_READBACK_EN
    logic [7:0] r_env3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_env3 <= 8'h00;
        end else if (r_state == S_RUN2) begin
            r_env3 <= w_ctx_nxt.env;
        end
    end

    assign ENV3 = r_env3;
`else
    assign ENV3 = 8'h00;
`endif

endmodule
